// File: rtl/rf_pkg.sv
// Shared types and constants for the 16x16 general-purpose register file.
// Build option RF_R0_ZERO_EN hardwires R0 to zero (see register_file).
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int NUM_REGS  = 2 ** RF_ADDR_W;

    typedef logic [RF_DATA_W-1:0] reg_data_t;
    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    localparam reg_data_t RESET_VAL = 16'h0000;

endpackage

// File: rtl/rf_register.sv
// One register-file word: load-enabled flop with asynchronous active-low clear.
// Instantiated once per architectural register by register_file.
module rf_register #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// 2-read / 1-write register file with combinational write-to-read bypass.
// Define RF_R0_ZERO_EN to hardwire R0 to zero (writes to R0 are dropped).
module register_file
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0]  wr_sel;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic              byp1;
    logic              byp2;

    always_comb begin
        wr_sel = '0;
        if (WriteReg) begin
            wr_sel[DstReg] = 1'b1;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
`ifdef RF_R0_ZERO_EN
        if (i == 0) begin : g_zero
            assign regs_q[i] = '0;
        end else begin : g_word
            rf_register #(
                .W       (DATA_W),
                .RST_VAL (DATA_W'(RESET_VAL))
            ) u_reg (
                .clk   (clk),
                .rst   (rst),
                .wr_en (wr_sel[i]),
                .d     (DstData),
                .q     (regs_q[i])
            );
        end
`else
        rf_register #(
            .W       (DATA_W),
            .RST_VAL (DATA_W'(RESET_VAL))
        ) u_reg (
            .clk   (clk),
            .rst   (rst),
            .wr_en (wr_sel[i]),
            .d     (DstData),
            .q     (regs_q[i])
        );
`endif
    end

    // Bypass lets an operand read in the writeback cycle see the new value.
`ifdef RF_R0_ZERO_EN
    assign byp1 = rst && WriteReg && (DstReg == SrcReg1) && (SrcReg1 != '0);
    assign byp2 = rst && WriteReg && (DstReg == SrcReg2) && (SrcReg2 != '0);
`else
    assign byp1 = rst && WriteReg && (DstReg == SrcReg1);
    assign byp2 = rst && WriteReg && (DstReg == SrcReg2);
`endif

    always_comb begin
        SrcData1 = regs_q[SrcReg1];
        SrcData2 = regs_q[SrcReg2];
        if (byp1) begin
            SrcData1 = DstData;
        end
        if (byp2) begin
            SrcData2 = DstData;
        end
        if (!rst) begin
            SrcData1 = '0;
            SrcData2 = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases plus random traffic
// compared against an array model of the sixteen registers.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  SrcReg1 = '0;
    logic [3:0]  SrcReg2 = '0;
    logic [3:0]  DstReg = '0;
    logic        WriteReg = 1'b0;
    logic [15:0] DstData = '0;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;

    logic [15:0] mdl [16];
    int n_vec = 0;
    int n_err = 0;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [3:0] idx);
        if (!rst) return 16'h0000;
`ifdef RF_R0_ZERO_EN
        if (idx == 4'd0) return 16'h0000;
`endif
        if (WriteReg && DstReg == idx) return DstData;
        return mdl[idx];
    endfunction

    task automatic check_ports(input string tag);
        chk({tag, "/p1"}, SrcData1, ref_rd(SrcReg1));
        chk({tag, "/p2"}, SrcData2, ref_rd(SrcReg2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && WriteReg) mdl[DstReg] = DstData;
        #1;
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        WriteReg = 1'b1;
        DstReg   = a;
        DstData  = d;
        tick();
        WriteReg = 1'b0;
    endtask

    initial begin
        logic [15:0] r0_exp;
        clear_mdl();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Async reset with live contents and a pending bypass-style write
        for (int i = 0; i < 16; i++) wr(4'(i), 16'(16'hBEEF ^ i));
        WriteReg = 1'b1;
        DstReg   = 4'd3;
        DstData  = 16'h5A5A;
        rst      = 1'b0;
        clear_mdl();
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(i);
            #0.5;
            chk("rst_p1", SrcData1, 16'h0000);
            chk("rst_p2", SrcData2, 16'h0000);
        end
        tick();
        WriteReg = 1'b0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(15 - i);
            #0.5;
            chk("post_rst_p1", SrcData1, 16'h0000);
            chk("post_rst_p2", SrcData2, 16'h0000);
        end
        tick();

        // R0 write/read
`ifdef RF_R0_ZERO_EN
        r0_exp = 16'h0000;
`else
        r0_exp = 16'h1111;
`endif
        WriteReg = 1'b1;
        DstReg   = 4'd0;
        DstData  = 16'h1111;
        SrcReg1  = 4'd0;
        #1;
        chk("r0_pre", SrcData1, r0_exp);
        tick();
        WriteReg = 1'b0;
        #1;
        chk("r0_post", SrcData1, r0_exp);

        // R15 bypass then stored
        WriteReg = 1'b1;
        DstReg   = 4'd15;
        DstData  = 16'hFFFF;
        SrcReg2  = 4'd15;
        #1;
        chk("byp15_pre", SrcData2, 16'hFFFF);
        tick();
        WriteReg = 1'b0;
        #1;
        chk("byp15_post", SrcData2, 16'hFFFF);

        // Write disable
        wr(4'd5, 16'hA5A5);
        WriteReg = 1'b0;
        DstReg   = 4'd5;
        DstData  = 16'h0000;
        SrcReg1  = 4'd5;
        tick();
        chk("wr_dis", SrcData1, 16'hA5A5);

        // Dual-port sweep
        for (int i = 0; i < 16; i++) wr(4'(i), 16'(16'h1000 + i));
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(15 - i);
            #0.5;
`ifdef RF_R0_ZERO_EN
            chk("sweep_p1", SrcData1, (i == 0) ? 16'h0000 : 16'(16'h1000 + i));
            chk("sweep_p2", SrcData2, (i == 15) ? 16'h0000 : 16'(16'h1000 + 15 - i));
`else
            chk("sweep_p1", SrcData1, 16'(16'h1000 + i));
            chk("sweep_p2", SrcData2, 16'(16'h1000 + 15 - i));
`endif
        end
        SrcReg1 = 4'd7;
        SrcReg2 = 4'd7;
        #1;
        chk("same_p1", SrcData1, 16'h1007);
        chk("same_p2", SrcData2, 16'h1007);
        tick();

        // Random traffic with occasional async reset
        for (int c = 0; c < 600; c++) begin
            WriteReg = 1'($urandom_range(0, 1));
            DstReg   = 4'($urandom_range(0, 15));
            DstData  = 16'($urandom());
            SrcReg1  = 4'($urandom_range(0, 15));
            SrcReg2  = ($urandom_range(0, 3) == 0) ? DstReg
                                                   : 4'($urandom_range(0, 15));
            #1;
            check_ports("rnd");
            SrcReg1 = 4'($urandom_range(0, 15));
            #1;
            check_ports("rnd_mux");
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                clear_mdl();
                #1;
                check_ports("rnd_rst");
                tick();
                rst = 1'b1;
                #1;
                check_ports("rnd_rel");
            end
            tick();
            check_ports("rnd_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
